dct_transpose_buffer: RTL and testbench

// - Row/column turn-around between 1-D DCT passes of the 8x8 2-D DCT. Takes the

---
 rtl/dct_transpose_buffer.sv | 176 +++++++++++++++++
 tb/tb_dct_transpose_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buffer.sv
// 8x8 transpose buffer between the row and column 1-D DCT passes: row-major fill, column-major drain.
// Optional output rounding/scaling is enabled by defining DCT_TP_SCALE_EN.
module dct_transpose_buffer #(
    parameter int BITS  = 25,
    parameter int SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] din,
    input  logic            din_sync,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    output logic            dout_sync,
    output logic            blk_start,
    output logic            sync_err
);

`ifdef DCT_TP_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif
    localparam logic [BITS-1:0] RND = BITS'(1) << (SHIFT - 1);

    typedef enum logic { W_IDLE, W_FILL }  w_state_t;
    typedef enum logic { R_IDLE, R_DRAIN } r_state_t;

    logic [BITS-1:0] mem [0:127];

    w_state_t   w_state, w_state_next;
    logic       wr_bank, wr_bank_next;
    logic [2:0] row, row_next, col, col_next;
    logic [2:0] wr_row, wr_col;
    logic       wr_en, launch, err_next;

    r_state_t   r_state, r_state_next;
    logic       rd_bank, rd_bank_next;
    logic [5:0] k, k_next;
    logic       rd_en;

    logic [BITS-1:0] rd_data;
    logic            rd_valid;
    logic [5:0]      rd_k;

    logic [BITS-1:0] sum, scaled, out_word;
    logic [BITS-2:0] mag_scaled;

    always_comb begin
        w_state_next = w_state;
        wr_bank_next = wr_bank;
        row_next     = row;
        col_next     = col;
        wr_row       = row;
        wr_col       = col;
        wr_en        = 1'b0;
        launch       = 1'b0;
        err_next     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (din_sync) begin
                    wr_en        = 1'b1;
                    wr_row       = '0;
                    wr_col       = '0;
                    row_next     = '0;
                    col_next     = 3'd1;
                    w_state_next = W_FILL;
                end
            end
            W_FILL: begin
                wr_en = 1'b1;
                if (din_sync && col != 3'd0) begin
                    // Misplaced sync: restart the current row at column 0.
                    err_next = 1'b1;
                    wr_col   = '0;
                    col_next = 3'd1;
                end else if (col == 3'd7) begin
                    col_next = '0;
                    if (row == 3'd7) begin
                        row_next     = '0;
                        wr_bank_next = ~wr_bank;
                        launch       = 1'b1;
                    end else begin
                        row_next = row + 3'd1;
                    end
                end else begin
                    col_next = col + 3'd1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            wr_bank  <= 1'b0;
            row      <= '0;
            col      <= '0;
            sync_err <= 1'b0;
        end else begin
            w_state  <= w_state_next;
            wr_bank  <= wr_bank_next;
            row      <= row_next;
            col      <= col_next;
            sync_err <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[{wr_bank, wr_row, wr_col}] <= din;
    end

    // A launch overrides the end-of-block return to idle, giving gapless output.
    always_comb begin
        r_state_next = r_state;
        rd_bank_next = rd_bank;
        k_next       = k;
        rd_en        = 1'b0;
        if (r_state == R_DRAIN) begin
            rd_en  = 1'b1;
            k_next = k + 6'd1;
            if (k == 6'd63)
                r_state_next = R_IDLE;
        end
        if (launch) begin
            r_state_next = R_DRAIN;
            rd_bank_next = wr_bank;
            k_next       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            rd_bank  <= 1'b0;
            k        <= '0;
            rd_valid <= 1'b0;
            rd_k     <= '0;
        end else begin
            r_state  <= r_state_next;
            rd_bank  <= rd_bank_next;
            k        <= k_next;
            rd_valid <= rd_en;
            rd_k     <= k;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[{rd_bank, k[2:0], k[5:3]}];
    end

    always_comb begin
        sum        = {1'b0, rd_data[BITS-2:0]} + RND;
        mag_scaled = (BITS-1)'(sum >> SHIFT);
        scaled     = {rd_data[BITS-1] & (mag_scaled != '0), mag_scaled};
        out_word   = SCALE_EN ? scaled : rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sync  <= 1'b0;
            blk_start  <= 1'b0;
        end else begin
            dout_valid <= rd_valid;
            dout_sync  <= rd_valid && (rd_k[2:0] == 3'd0);
            blk_start  <= rd_valid && (rd_k == 6'd0);
            if (rd_valid)
                dout <= out_word;
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer: reset, transpose, back-to-back, resync, reset mid-drain, scaling.
// Outputs are logged per clock edge (1 ns after it) and checked against hand-derived schedules afterwards.
module tb_dct_transpose_buffer;
    localparam int BITS = 25;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] din = '0;
    logic            din_sync = 1'b0;
    logic [BITS-1:0] dout;
    logic            dout_valid, dout_sync, blk_start, sync_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic            ov [0:2047];
    logic [BITS-1:0] od [0:2047];
    logic            os [0:2047];
    logic            ob [0:2047];
    logic            oe [0:2047];

    always #5 clk = ~clk;

    dct_transpose_buffer #(.BITS(BITS), .SHIFT(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_sync(din_sync),
        .dout(dout), .dout_valid(dout_valid), .dout_sync(dout_sync),
        .blk_start(blk_start), .sync_err(sync_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample, take the edge, log the outputs it produced.
    task automatic tick(input logic [BITS-1:0] d, input logic s);
        din = d;
        din_sync = s;
        @(posedge clk);
        #1;
        ov[cyc] = dout_valid;
        od[cyc] = dout;
        os[cyc] = dout_sync;
        ob[cyc] = blk_start;
        oe[cyc] = sync_err;
        cyc++;
    endtask

    task automatic feed_block(input int base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                tick(BITS'(base + 8*r + c), c == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick('0, 1'b0);
        rst = 1'b0;
    endtask

    function automatic logic [BITS-1:0] model(input logic [BITS-1:0] v);
`ifdef DCT_TP_SCALE_EN
        int unsigned q;
        q = (int'(v[BITS-2:0]) + 2) / 4;
        return {(q != 0) ? v[BITS-1] : 1'b0, (BITS-1)'(q)};
`else
        return v;
`endif
    endfunction

    // Transposed element i of a block filled with base + 8*r + c.
    function automatic logic [BITS-1:0] tp(input int base, input int i);
        return model(BITS'(base + 8*(i % 8) + i / 8));
    endfunction

    task automatic check_block(input string tag, input int t, input int base);
        for (int i = 0; i < 64; i++) begin
            check_eq({tag, "_valid"}, 32'(ov[t+i]), 32'd1);
            check_eq({tag, "_data"},  32'(od[t+i]), 32'(tp(base, i)));
            check_eq({tag, "_sync"},  32'(os[t+i]), 32'(i % 8 == 0));
            check_eq({tag, "_blk"},   32'(ob[t+i]), 32'(i == 0));
        end
    endtask

    initial begin
        int t0, t1, n;

        // Reset with random inputs, then unsynced data must be ignored.
        for (int i = 0; i < 3; i++) begin
            tick(BITS'($urandom), 1'($urandom));
            check_eq("rst_valid", 32'(dout_valid), 32'd0);
            check_eq("rst_dout",  32'(dout), 32'd0);
            check_eq("rst_sync",  32'(dout_sync), 32'd0);
            check_eq("rst_blk",   32'(blk_start), 32'd0);
            check_eq("rst_err",   32'(sync_err), 32'd0);
        end
        rst = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 80; i++) tick(BITS'($urandom), 1'b0);
        n = 0;
        for (int i = t0; i < cyc; i++) n += int'(ov[i]) + int'(oe[i]);
        check_eq("presync_quiet", 32'(n), 32'd0);

        // Single block transpose.
        t0 = cyc;
        feed_block(0);
        repeat (66) tick('0, 1'b0);
        check_eq("tp_latency", 32'(ov[t0+64]), 32'd0);
        check_block("tp", t0 + 65, 0);
        do_reset();

        // Three blocks back-to-back.
        t0 = cyc;
        for (int b = 0; b < 3; b++) feed_block(100 * b);
        repeat (66) tick('0, 1'b0);
        check_eq("b2b_latency", 32'(ov[t0+64]), 32'd0);
        for (int b = 0; b < 3; b++) check_block("b2b", t0 + 65 + 64*b, 100 * b);
        do_reset();

        // Resync at row 2, column 5: row 2 restarts, block ends 5 samples late.
        t0 = cyc;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) tick(BITS'(8*r + c), c == 0);
        for (int c = 0; c < 5; c++) tick(BITS'(900 + c), c == 0);
        tick(BITS'(16), 1'b1);
        for (int c = 1; c < 8; c++) tick(BITS'(16 + c), 1'b0);
        for (int r = 3; r < 8; r++)
            for (int c = 0; c < 8; c++) tick(BITS'(8*r + c), c == 0);
        repeat (70) tick('0, 1'b0);
        check_eq("rs_err_before", 32'(oe[t0+20]), 32'd0);
        check_eq("rs_err_pulse",  32'(oe[t0+21]), 32'd1);
        check_eq("rs_err_after",  32'(oe[t0+22]), 32'd0);
        n = 0;
        for (int i = t0; i < cyc; i++) n += int'(oe[i]);
        check_eq("rs_err_count", 32'(n), 32'd1);
        check_eq("rs_latency", 32'(ov[t0+69]), 32'd0);
        check_block("rs", t0 + 70, 0);
        do_reset();

        // Reset while draining element 30.
        t0 = cyc;
        feed_block(0);
        repeat (31) tick('0, 1'b0);
        check_eq("mid_k29_valid", 32'(ov[t0+94]), 32'd1);
        check_eq("mid_k29_data",  32'(od[t0+94]), 32'(model(BITS'(43))));
        rst = 1'b1;
        tick('0, 1'b0);
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(ov[t0+95]), 32'd0);
        check_eq("mid_rst_dout",  32'(od[t0+95]), 32'd0);
        t1 = cyc;
        for (int i = 0; i < 80; i++) tick(BITS'($urandom), 1'b0);
        n = 0;
        for (int i = t1; i < cyc; i++) n += int'(ov[i]);
        check_eq("mid_quiet", 32'(n), 32'd0);
        t1 = cyc;
        feed_block(200);
        repeat (3) tick('0, 1'b0);
        check_eq("mid_new_latency", 32'(ov[t1+64]), 32'd0);
        check_eq("mid_new_valid",   32'(ov[t1+65]), 32'd1);
        check_eq("mid_new_blk",     32'(ob[t1+65]), 32'd1);
        check_eq("mid_new_d0",      32'(od[t1+65]), 32'(model(BITS'(200))));
        check_eq("mid_new_d1",      32'(od[t1+66]), 32'(model(BITS'(208))));
        do_reset();

        // Sign-magnitude words in row 0; read back as elements k=0,8,16,24.
        t0 = cyc;
        tick(25'h0000006, 1'b1);
        tick(25'h1000006, 1'b0);
        tick(25'h1000001, 1'b0);
        tick(25'h1000002, 1'b0);
        for (int c = 4; c < 8; c++) tick('0, 1'b0);
        for (int r = 1; r < 8; r++)
            for (int c = 0; c < 8; c++) tick('0, c == 0);
        repeat (30) tick('0, 1'b0);
`ifdef DCT_TP_SCALE_EN
        check_eq("scale_pos6",  32'(od[t0+65]), 32'h0000002);
        check_eq("scale_neg6",  32'(od[t0+73]), 32'h1000002);
        check_eq("scale_neg1",  32'(od[t0+81]), 32'h0000000);
        check_eq("scale_neg2",  32'(od[t0+89]), 32'h1000001);
`else
        check_eq("raw_pos6",    32'(od[t0+65]), 32'h0000006);
        check_eq("raw_neg6",    32'(od[t0+73]), 32'h1000006);
        check_eq("raw_neg1",    32'(od[t0+81]), 32'h1000001);
        check_eq("raw_neg2",    32'(od[t0+89]), 32'h1000002);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
